// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the multi-requester Wishbone to SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ERR   = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: returns the first requesting index after the last owner,
// wrapping from NUM_M-1 back to 0.
module rr_picker #(
    parameter int NUM_M = 4,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand [NUM_M];

    // cand[k] is the index k+1 places after the last owner.
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_cand
        assign cand[gi] = IDX_W'((int'(last) + gi + 1) % NUM_M);
    end

    // Scan from the far end so the nearest requester wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx   = cand[k];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller Wishbone port among NUM_M
// requesters, holding the grant for whole bus cycles and timing out stalled strobes.
module wb_sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_M-1:0]              m_cyc_i,
    input  logic [NUM_M-1:0]              m_stb_i,
    input  logic [NUM_M-1:0]              m_we_i,
    input  logic [NUM_M*ADDR_W-1:0]       m_addr_i,
    input  logic [NUM_M*DATA_W-1:0]       m_dat_i,
    input  logic [NUM_M*(DATA_W/8)-1:0]   m_sel_i,
    input  logic [NUM_M*3-1:0]            m_cti_i,
    output logic [DATA_W-1:0]             m_dat_o,
    output logic [NUM_M-1:0]              m_ack_o,
    output logic [NUM_M-1:0]              m_err_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_dat_o,
    output logic [DATA_W/8-1:0]           s_sel_o,
    output logic [2:0]                    s_cti_o,
    input  logic                          s_ack_i,
    input  logic [DATA_W-1:0]             s_dat_i
);

    localparam int SEL_W  = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_M);
    localparam int WAIT_W = $clog2(TIMEOUT);

    arb_state_t        state_reg;
    logic [IDX_W-1:0]  grant_idx_reg;
    logic [IDX_W-1:0]  last_grant_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;
    logic              err_reg;

    logic [ADDR_W-1:0] addr_arr [NUM_M];
    logic [DATA_W-1:0] dat_arr  [NUM_M];
    logic [SEL_W-1:0]  sel_arr  [NUM_M];
    logic [2:0]        cti_arr  [NUM_M];

    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
        assign addr_arr[gi] = m_addr_i[gi*ADDR_W +: ADDR_W];
        assign dat_arr[gi]  = m_dat_i[gi*DATA_W +: DATA_W];
        assign sel_arr[gi]  = m_sel_i[gi*SEL_W +: SEL_W];
        assign cti_arr[gi]  = m_cti_i[gi*3 +: 3];
    end

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_picker #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (m_cyc_i),
        .last  (last_grant_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    logic granted;
    logic cyc_g;
    logic stb_g;
    logic timeout_hit;

    assign granted = (state_reg == GRANT);
    assign cyc_g   = m_cyc_i[grant_idx_reg];
    assign stb_g   = m_stb_i[grant_idx_reg];

    always_comb begin
        wait_next = wait_reg;
        if (s_ack_i || !stb_g) begin
            wait_next = '0;
        end else begin
            wait_next = wait_reg + 1'b1;
        end
    end

    assign timeout_hit = stb_g && !s_ack_i && (wait_next == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            grant_idx_reg  <= '0;
            last_grant_reg <= IDX_W'(NUM_M - 1);
            wait_reg       <= '0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    wait_reg <= '0;
                    if (pick_valid) begin
                        grant_idx_reg <= pick_idx;
                        state_reg     <= GRANT;
                    end
                end
                GRANT: begin
                    // A release wins over a simultaneous timeout; the ack in that cycle is still delivered.
                    if (!cyc_g) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= grant_idx_reg;
                        wait_reg       <= '0;
                    end else if (timeout_hit) begin
                        state_reg <= ERR;
                        err_reg   <= 1'b1;
                        wait_reg  <= '0;
                    end else begin
                        wait_reg <= wait_next;
                    end
                end
                ERR: begin
                    if (!cyc_g) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= grant_idx_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign s_cyc_o  = granted & cyc_g;
    assign s_stb_o  = granted & stb_g;
    assign s_we_o   = granted & m_we_i[grant_idx_reg];
    assign s_addr_o = granted ? addr_arr[grant_idx_reg] : '0;
    assign s_dat_o  = granted ? dat_arr[grant_idx_reg]  : '0;
    assign s_sel_o  = granted ? sel_arr[grant_idx_reg]  : '0;
    assign s_cti_o  = granted ? cti_arr[grant_idx_reg]  : '0;
    assign m_dat_o  = s_dat_i;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (granted && stb_g && s_ack_i) begin
            m_ack_o[grant_idx_reg] = 1'b1;
        end
        if (err_reg) begin
            m_err_o[grant_idx_reg] = 1'b1;
        end
    end

endmodule
